// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter between NUM_REQ byte producers
// Ports:
//   CLK, RST              clock (rising edge), synchronous active-high reset
//   en                    1 = new grants allowed, 0 = only finish the in-flight frame
//   req_valid, req_data   per-requester pending flag and flattened bytes (i at [i*DATA_W +: DATA_W])
//   req_ready             one-hot accept pulse to the granted requester
//   tx_p_data, tx_data_valid, tx_busy   UART_TX P_DATA / DATA_VALID / busy
//   grant_id              index of the last granted requester
//   tx_done, tx_err       one-cycle pulses: frame completed / busy never rose within BUSY_TO
module uart_tx_arbiter #(
    parameter int DATA_W  = 8,
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int BUSY_TO = 8
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      en,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [DATA_W-1:0]         tx_p_data,
    output logic                      tx_data_valid,
    input  logic                      tx_busy,
    output logic [ID_W-1:0]           grant_id,
    output logic                      tx_done,
    output logic                      tx_err
);
    localparam int CW = $clog2(BUSY_TO + 1);

    typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;

    state_t              state, state_n;
    logic [ID_W-1:0]     ptr, ptr_n, win, ptr_inc, gid_n;
    logic [CW-1:0]       cnt, cnt_n;
    logic                found, dv_n, done_n, err_n;
    logic [NUM_REQ-1:0]  ready_n;
    logic [DATA_W-1:0]   p_data_n;

    // Index arithmetic modulo NUM_REQ, which need not be a power of two.
    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] a, input int k);
        int s;
        s = int'(a) + k;
        return ID_W'(s >= NUM_REQ ? s - NUM_REQ : s);
    endfunction

    assign ptr_inc = wrap_add(grant_id, 1);

    // Scan from the farthest offset back to ptr so the nearest pending requester wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[wrap_add(ptr, k)]) begin
                found = 1'b1;
                win   = wrap_add(ptr, k);
            end
        end
    end

    always_comb begin
        state_n  = state;
        ptr_n    = ptr;
        cnt_n    = cnt;
        p_data_n = tx_p_data;
        gid_n    = grant_id;
        dv_n     = 1'b0;
        ready_n  = '0;
        done_n   = 1'b0;
        err_n    = 1'b0;
        case (state)
            IDLE: begin
                if (en && !tx_busy && found) begin
                    state_n  = WAIT_BUSY;
                    cnt_n    = '0;
                    p_data_n = req_data[win*DATA_W +: DATA_W];
                    gid_n    = win;
                    dv_n     = 1'b1;
                    ready_n  = NUM_REQ'(1) << win;
                end
            end
            WAIT_BUSY: begin
                cnt_n = cnt + CW'(1);
                if (tx_busy) begin
                    state_n = WAIT_DONE;
                end else if (cnt_n == CW'(BUSY_TO)) begin
                    err_n   = 1'b1;
                    ptr_n   = ptr_inc;
                    state_n = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    done_n  = 1'b1;
                    ptr_n   = ptr_inc;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= IDLE;
            ptr           <= '0;
            cnt           <= '0;
            tx_p_data     <= '0;
            grant_id      <= '0;
            tx_data_valid <= 1'b0;
            req_ready     <= '0;
            tx_done       <= 1'b0;
            tx_err        <= 1'b0;
        end else begin
            state         <= state_n;
            ptr           <= ptr_n;
            cnt           <= cnt_n;
            tx_p_data     <= p_data_n;
            grant_id      <= gid_n;
            tx_data_valid <= dv_n;
            req_ready     <= ready_n;
            tx_done       <= done_n;
            tx_err        <= err_n;
        end
    end
endmodule
